cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 18 +
 rtl/cdb_fifo.sv | 55 +++++
 rtl/cdb_arbiter.sv | 129 ++++++++++++
 tb/tb_cdb_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter: ROB tag and data widths,
// source encodings and the queued {rob_pos, val} entry layout.
package cdb_arbiter_pkg;

  localparam int ROB_POS_WID = 4;
  localparam int DATA_WID    = 32;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  typedef struct packed {
    logic [ROB_POS_WID-1:0] rob_pos;
    logic [DATA_WID-1:0]    val;
  } cdb_entry_t;

  localparam int ENTRY_WID = $bits(cdb_entry_t);

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result queue: DEPTH entries (power of two), pointers wrap
// naturally, full/empty come straight from the registered occupancy count.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A full queue still accepts a push when its head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging ALU and LSB results onto one registered CDB.
// A request is accepted when *_full is low; CDB_BYPASS_EN lets a request to an empty queue skip it.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   alu_result,
  input  logic [ROB_POS_WID-1:0] alu_result_rob_pos,
  input  logic [DATA_WID-1:0]    alu_result_val,
  input  logic                   lsb_result,
  input  logic [ROB_POS_WID-1:0] lsb_result_rob_pos,
  input  logic [DATA_WID-1:0]    lsb_result_val,
  output logic                   alu_full,
  output logic                   lsb_full,
  output logic                   cdb_valid,
  output logic [ROB_POS_WID-1:0] cdb_rob_pos,
  output logic [DATA_WID-1:0]    cdb_val,
  output logic                   cdb_src,
  output logic                   ovf_err
);

  cdb_entry_t alu_entry, lsb_entry, alu_head, lsb_head, alu_data, lsb_data;
  logic active, flush;
  logic alu_req, lsb_req;
  logic alu_empty, lsb_empty;
  logic alu_byp, lsb_byp;
  logic alu_cand, lsb_cand;
  logic grant_alu, grant_lsb;
  logic alu_push, lsb_push, alu_pop, lsb_pop;
  logic ovf_next;
  logic rr_ptr;

  assign active = rdy && !rollback;
  assign flush  = rdy && rollback;

  assign alu_req = alu_result && active;
  assign lsb_req = lsb_result && active;

  assign alu_entry.rob_pos = alu_result_rob_pos;
  assign alu_entry.val     = alu_result_val;
  assign lsb_entry.rob_pos = lsb_result_rob_pos;
  assign lsb_entry.val     = lsb_result_val;

`ifdef CDB_BYPASS_EN
  assign alu_byp = alu_req && alu_empty;
  assign lsb_byp = lsb_req && lsb_empty;
`else
  assign alu_byp = 1'b0;
  assign lsb_byp = 1'b0;
`endif

  assign alu_cand = !alu_empty || alu_byp;
  assign lsb_cand = !lsb_empty || lsb_byp;

  assign grant_alu = active && alu_cand && (!lsb_cand || rr_ptr == SRC_ALU);
  assign grant_lsb = active && lsb_cand && (!alu_cand || rr_ptr == SRC_LSB);

  // A winning bypass goes straight to the CDB; a losing one is queued.
  assign alu_pop  = grant_alu && !alu_empty;
  assign lsb_pop  = grant_lsb && !lsb_empty;
  assign alu_push = alu_req && !(alu_byp && grant_alu);
  assign lsb_push = lsb_req && !(lsb_byp && grant_lsb);

  assign alu_data = alu_byp ? alu_entry : alu_head;
  assign lsb_data = lsb_byp ? lsb_entry : lsb_head;

  assign ovf_next = (alu_push && alu_full && !alu_pop) ||
                    (lsb_push && lsb_full && !lsb_pop);

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_WID)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (alu_push),
    .pop   (alu_pop),
    .din   (alu_entry),
    .head  (alu_head),
    .full  (alu_full),
    .empty (alu_empty)
  );

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_WID)) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .din   (lsb_entry),
    .head  (lsb_head),
    .full  (lsb_full),
    .empty (lsb_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid   <= 1'b0;
      cdb_src     <= SRC_ALU;
      cdb_rob_pos <= '0;
      cdb_val     <= '0;
      rr_ptr      <= SRC_ALU;
      ovf_err     <= 1'b0;
    end else if (rdy) begin
      if (ovf_next) ovf_err <= 1'b1;
      if (rollback) begin
        cdb_valid <= 1'b0;
        rr_ptr    <= SRC_ALU;
      end else begin
        cdb_valid <= grant_alu || grant_lsb;
        if (grant_alu) begin
          cdb_src     <= SRC_ALU;
          cdb_rob_pos <= alu_data.rob_pos;
          cdb_val     <= alu_data.val;
        end else if (grant_lsb) begin
          cdb_src     <= SRC_LSB;
          cdb_rob_pos <= lsb_data.rob_pos;
          cdb_val     <= lsb_data.val;
        end
        // The pointer only moves when both sources actually contended.
        if (alu_cand && lsb_cand) rr_ptr <= grant_alu ? SRC_LSB : SRC_ALU;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: cycle table for the queued path, scoreboard-checked
// sequences for ordering, rollback, overflow, stall and reset. Honors CDB_BYPASS_EN.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int EW    = 1 + ROB_POS_WID + DATA_WID;

  logic clk = 1'b0;
  logic rst, rdy, rollback;
  logic alu_result, lsb_result;
  logic [ROB_POS_WID-1:0] alu_result_rob_pos, lsb_result_rob_pos;
  logic [DATA_WID-1:0]    alu_result_val, lsb_result_val;
  logic alu_full, lsb_full, cdb_valid, cdb_src, ovf_err;
  logic [ROB_POS_WID-1:0] cdb_rob_pos;
  logic [DATA_WID-1:0]    cdb_val;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic sb_en = 1'b0;
  logic mon_upd;

  cdb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
    .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val),
    .alu_full(alu_full), .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val), .cdb_src(cdb_src),
    .ovf_err(ovf_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    alu_result = 1'b0; alu_result_rob_pos = '0; alu_result_val = '0;
    lsb_result = 1'b0; lsb_result_rob_pos = '0; lsb_result_val = '0;
    rollback = 1'b0;
    rdy = 1'b1;
  endtask

  task automatic drive(input logic a, input logic [ROB_POS_WID-1:0] ap, input logic [DATA_WID-1:0] av,
                       input logic l, input logic [ROB_POS_WID-1:0] lp, input logic [DATA_WID-1:0] lv);
    alu_result = a; alu_result_rob_pos = ap; alu_result_val = av;
    lsb_result = l; lsb_result_rob_pos = lp; lsb_result_val = lv;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic src, input logic [ROB_POS_WID-1:0] pos,
                                        input logic [DATA_WID-1:0] val);
    return {src, pos, val};
  endfunction

  // Pops one expected broadcast for every edge that actually updated the CDB.
  always @(posedge clk) begin
    mon_upd = rdy && !rst && sb_en;
    #1;
    if (mon_upd && cdb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no broadcast", {cdb_src, cdb_rob_pos, cdb_val});
      end else begin
        check("sb_bcast", 64'({cdb_src, cdb_rob_pos, cdb_val}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) tick();
    tick();
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic a; logic [ROB_POS_WID-1:0] ap; logic [DATA_WID-1:0] av;
    logic l; logic [ROB_POS_WID-1:0] lp; logic [DATA_WID-1:0] lv;
    logic v; logic s; logic [ROB_POS_WID-1:0] p; logic [DATA_WID-1:0] d;
    logic af; logic lf;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic a, input logic [3:0] ap, input logic [31:0] av,
                              input logic l, input logic [3:0] lp, input logic [31:0] lv,
                              input logic v, input logic s, input logic [3:0] p, input logic [31:0] d,
                              input logic af, input logic lf);
    vec_t r;
    r.a = a; r.ap = ap; r.av = av; r.l = l; r.lp = lp; r.lv = lv;
    r.v = v; r.s = s; r.p = p; r.d = d; r.af = af; r.lf = lf;
    return r;
  endfunction

  // ---------------- test sequence ----------------
  logic [DATA_WID-1:0] av[4];
  logic [DATA_WID-1:0] lv[4];
  logic [DATA_WID-1:0] rv0, rv1, rv2;
  int ai, li;
  logic seen_af, seen_lf;

  initial begin
    tbl[0]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,  0,            0, 0);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,  0,            0, 0);
    tbl[2]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,  0,            0, 0);
    tbl[3]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,  0,            0, 0);
    tbl[4]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0,            0, 0, 0,  0,            0, 0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 0,            1, 0, 3,  32'hDEADBEEF, 0, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 3,  32'hDEADBEEF, 0, 0);
    tbl[7]  = mk(1, 1, 32'h11,       1, 2, 32'h22,       0, 0, 3,  32'hDEADBEEF, 0, 0);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,            1, 0, 1,  32'h11,       0, 0);
    tbl[9]  = mk(0, 0, 0,            0, 0, 0,            1, 1, 2,  32'h22,       0, 0);
    tbl[10] = mk(0, 0, 0,            0, 0, 0,            0, 1, 2,  32'h22,       0, 0);
    tbl[11] = mk(1, 4, 32'h44,       1, 5, 32'h55,       0, 1, 2,  32'h22,       0, 0);
    tbl[12] = mk(0, 0, 0,            0, 0, 0,            1, 1, 5,  32'h55,       0, 0);
    tbl[13] = mk(0, 0, 0,            0, 0, 0,            1, 0, 4,  32'h44,       0, 0);
    tbl[14] = mk(1, 8, 32'h88,       1, 9, 32'h99,       0, 0, 4,  32'h44,       0, 0);
    tbl[15] = mk(1, 10, 32'hAA,      1, 11, 32'hBB,      1, 0, 8,  32'h88,       0, 1);
    tbl[16] = mk(0, 0, 0,            0, 0, 0,            1, 1, 9,  32'h99,       0, 0);
    tbl[17] = mk(0, 0, 0,            0, 0, 0,            1, 0, 10, 32'hAA,       0, 0);
    tbl[18] = mk(0, 0, 0,            0, 0, 0,            1, 1, 11, 32'hBB,       0, 0);
    tbl[19] = mk(0, 0, 0,            0, 0, 0,            0, 1, 11, 32'hBB,       0, 0);

    do_reset();
    check("reset_state", 64'({cdb_valid, cdb_src, cdb_rob_pos, cdb_val, alu_full, lsb_full, ovf_err}), 64'd0);

`ifndef CDB_BYPASS_EN
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].a, tbl[i].ap, tbl[i].av, tbl[i].l, tbl[i].lp, tbl[i].lv);
      tick();
      check($sformatf("tbl_%0d", i),
            64'({cdb_valid, cdb_src, cdb_rob_pos, cdb_val, alu_full, lsb_full, ovf_err}),
            64'({tbl[i].v, tbl[i].s, tbl[i].p, tbl[i].d, tbl[i].af, tbl[i].lf, 1'b0}));
    end
`else
    for (int i = 0; i < 4; i++) tick();
    drive(1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'd0);
    tick();
    idle_inputs();
    check("byp_latency", 64'({cdb_valid, cdb_src, cdb_rob_pos, cdb_val}), 64'({1'b1, 1'b0, 4'd3, 32'hDEADBEEF}));
    tick();
    check("byp_valid_drop", 64'(cdb_valid), 64'd0);
`endif

    // Alternation under back-pressure: each source offers 4 results.
    do_reset();
    sb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      av[i] = $urandom;
      lv[i] = $urandom;
      exp_q.push_back(ent(SRC_ALU, 4'(i), av[i]));
      exp_q.push_back(ent(SRC_LSB, 4'(8 + i), lv[i]));
    end
    ai = 0; li = 0; seen_af = 1'b0; seen_lf = 1'b0;
    for (int c = 0; c < 40 && (ai < 4 || li < 4); c++) begin
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      if (ai < 4 && !alu_full) begin
        alu_result = 1'b1; alu_result_rob_pos = 4'(ai); alu_result_val = av[ai]; ai++;
      end
      if (li < 4 && !lsb_full) begin
        lsb_result = 1'b1; lsb_result_rob_pos = 4'(8 + li); lsb_result_val = lv[li]; li++;
      end
      tick();
      if (alu_full) seen_af = 1'b1;
      if (lsb_full) seen_lf = 1'b1;
    end
    idle_inputs();
    wait_drain("alt_drain");
`ifndef CDB_BYPASS_EN
    check("alt_full_seen", 64'({seen_af, seen_lf}), 64'd3);
`endif
    check("alt_no_ovf", 64'(ovf_err), 64'd0);

    // Rollback with both queues occupied.
    do_reset();
    sb_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      av[i] = $urandom_range(1, 32'hFFFF);
      lv[i] = $urandom_range(1, 32'hFFFF);
    end
    exp_q.push_back(ent(SRC_ALU, 4'd1, av[0]));
    exp_q.push_back(ent(SRC_LSB, 4'd9, lv[0]));
`ifdef CDB_BYPASS_EN
    exp_q.push_back(ent(SRC_ALU, 4'd2, av[1]));
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'(1 + i), av[i], 1, 4'(9 + i), lv[i]);
      tick();
    end
    drive(1, 4'd5, 32'h5, 1, 4'd6, 32'h6);
    rollback = 1'b1;
    tick();
    idle_inputs();
    check("rb_valid", 64'(cdb_valid), 64'd0);
    check("rb_full", 64'({alu_full, lsb_full}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rb_idle", 64'(cdb_valid), 64'd0);
    end
    check("rb_queue", 64'(exp_q.size()), 64'd0);
    rv0 = $urandom; rv1 = $urandom; rv2 = $urandom;
    exp_q.push_back(ent(SRC_LSB, 4'd13, rv0));
    exp_q.push_back(ent(SRC_ALU, 4'd14, rv1));
    exp_q.push_back(ent(SRC_LSB, 4'd15, rv2));
    drive(0, 4'd0, 32'd0, 1, 4'd13, rv0);
    tick();
    drive(1, 4'd14, rv1, 1, 4'd15, rv2);
    tick();
    idle_inputs();
    wait_drain("rb_after_drain");

    // Overflow: both sources push every cycle regardless of full.
    do_reset();
    check("ovf_reset", 64'(ovf_err), 64'd0);
`ifndef CDB_BYPASS_EN
    sb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      av[i] = $urandom;
      lv[i] = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ent(SRC_ALU, 4'(i), av[i]));
      if (i < 3) exp_q.push_back(ent(SRC_LSB, 4'(8 + i), lv[i]));
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'(i), av[i], 1, 4'(8 + i), lv[i]);
      tick();
      if (i == 2) check("ovf_before_drop", 64'(ovf_err), 64'd0);
    end
    idle_inputs();
    check("ovf_set", 64'(ovf_err), 64'd1);
    wait_drain("ovf_drain");
`else
    sb_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'(i), $urandom, 1, 4'(8 + i), $urandom);
      tick();
    end
    idle_inputs();
    check("ovf_set", 64'(ovf_err), 64'd1);
    for (int i = 0; i < 10; i++) tick();
`endif
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    check("ovf_rollback", 64'(ovf_err), 64'd1);
    tick();
    check("ovf_hold", 64'(ovf_err), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_rst", 64'(ovf_err), 64'd0);

    // rdy low for three cycles with queued entries.
    do_reset();
    sb_en = 1'b1;
    av[0] = $urandom; av[1] = $urandom; lv[0] = $urandom; lv[1] = $urandom;
    exp_q.push_back(ent(SRC_ALU, 4'd1, av[0]));
    exp_q.push_back(ent(SRC_LSB, 4'd9, lv[0]));
    exp_q.push_back(ent(SRC_ALU, 4'd2, av[1]));
    exp_q.push_back(ent(SRC_LSB, 4'd10, lv[1]));
    drive(1, 4'd1, av[0], 1, 4'd9, lv[0]);
    tick();
    drive(1, 4'd2, av[1], 1, 4'd10, lv[1]);
    tick();
    drive(1, 4'd7, 32'h77, 1, 4'd7, 32'h77);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
`ifndef CDB_BYPASS_EN
      check("stall_hold", 64'({cdb_valid, cdb_src, cdb_rob_pos, cdb_val, alu_full, lsb_full}),
            64'({1'b1, SRC_ALU, 4'd1, av[0], 1'b0, 1'b1}));
`else
      check("stall_hold", 64'({cdb_valid, cdb_src, cdb_rob_pos, cdb_val, alu_full, lsb_full}),
            64'({1'b1, SRC_LSB, 4'd9, lv[0], 1'b0, 1'b0}));
`endif
    end
    idle_inputs();
    wait_drain("stall_resume");

    // Reset with both queues non-empty, while rollback and rdy=0 are also presented.
    do_reset();
    sb_en = 1'b0;
    drive(1, 4'd1, 32'hA1, 1, 4'd9, 32'hB1);
    tick();
    drive(1, 4'd2, 32'hA2, 1, 4'd10, 32'hB2);
    tick();
    rst = 1'b1; rollback = 1'b1; rdy = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_outputs", 64'({cdb_valid, cdb_src, cdb_rob_pos, cdb_val, alu_full, lsb_full, ovf_err}), 64'd0);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_empty", 64'(cdb_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
